// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : pops opcode/A/B from the operand FIFO, runs one ALU op, holds
//            the flagged result until acknowledged.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WAIT    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_zero,
  output logic                  res_carry,
  output logic                  res_ovf,
  output logic                  res_err,
  output logic                  res_valid,
  input  logic                  res_ack,
  output logic                  busy
);

  localparam int SHIFT_W = $clog2(DATA_WIDTH);
  localparam int CNT_W   = $clog2(RD_WAIT + 1);
  localparam int MSB     = DATA_WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_POP   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_EXEC  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           idx;
  logic [1:0]           idx_next;
  logic [CNT_W-1:0]     wait_cnt;
  logic [CNT_W-1:0]     wait_cnt_next;

  // Only the low nibble of the opcode word is meaningful, so only it is kept.
  logic [3:0]           op_code;
  logic [DATA_WIDTH-1:0] a_word;
  logic [DATA_WIDTH-1:0] b_word;

  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH-1:0] sub_res;
  logic [SHIFT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_carry;
  logic                  alu_ovf;
  logic                  alu_err;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_FETCH: begin
        if (!fifo_empty) state_next = ST_POP;
      end
      ST_POP: begin
        state_next    = ST_WAIT;
        wait_cnt_next = CNT_W'(RD_WAIT);
      end
      ST_WAIT: begin
        wait_cnt_next = wait_cnt - CNT_W'(1);
        if (wait_cnt == CNT_W'(1)) state_next = ST_LATCH;
      end
      ST_LATCH: begin
        if (idx == 2'd2) begin
          state_next = ST_EXEC;
          idx_next   = 2'd0;
        end else begin
          state_next = ST_FETCH;
          idx_next   = idx + 2'd1;
        end
      end
      ST_EXEC: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (res_ack) state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_FETCH;
        idx_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_FETCH;
      idx      <= 2'd0;
      wait_cnt <= '0;
      fifo_rd  <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      wait_cnt <= wait_cnt_next;
      // Registered so the strobe is high exactly while in POP.
      fifo_rd  <= (state_next == ST_POP);
    end
  end

  assign busy = !((state == ST_FETCH) && (idx == 2'd0));

  // ---------------------------------------------------------------- operand slots
  always_ff @(posedge clock) begin
    if (reset) begin
      op_code <= '0;
      a_word  <= '0;
      b_word  <= '0;
    end else if (state == ST_LATCH) begin
      case (idx)
        2'd0:    op_code <= fifo_dout[3:0];
        2'd1:    a_word  <= fifo_dout;
        default: b_word  <= fifo_dout;
      endcase
    end
  end

  // ---------------------------------------------------------------- ALU
  assign add_full = {1'b0, a_word} + {1'b0, b_word};
  assign sub_res  = a_word - b_word;
  assign shamt    = b_word[SHIFT_W-1:0];

  always_comb begin
    alu_data  = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op_code)
      OP_ADD: begin
        alu_data  = add_full[DATA_WIDTH-1:0];
        alu_carry = add_full[DATA_WIDTH];
        alu_ovf   = (a_word[MSB] == b_word[MSB]) && (add_full[MSB] != a_word[MSB]);
      end
      OP_SUB: begin
        alu_data  = sub_res;
        alu_carry = (a_word < b_word);
        alu_ovf   = (a_word[MSB] != b_word[MSB]) && (sub_res[MSB] != a_word[MSB]);
      end
      OP_AND:  alu_data = a_word & b_word;
      OP_OR:   alu_data = a_word | b_word;
      OP_XOR:  alu_data = a_word ^ b_word;
      OP_SLL:  alu_data = a_word << shamt;
      OP_SRL:  alu_data = a_word >> shamt;
      OP_SRA:  alu_data = $signed(a_word) >>> shamt;
      OP_SLT:  alu_data = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_word) < $signed(b_word))};
      OP_SLTU: alu_data = {{(DATA_WIDTH-1){1'b0}}, (a_word < b_word)};
      default: alu_err  = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_data  <= alu_data;
      res_zero  <= (alu_data == '0);
      res_carry <= alu_carry;
      res_ovf   <= alu_ovf;
      res_err   <= alu_err;
      res_valid <= 1'b1;
    end else if ((state == ST_DONE) && res_ack) begin
      res_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : bench for alu_op_sequencer with a queue FIFO and reference ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd;
  logic [W-1:0] res_data;
  logic         res_zero;
  logic         res_carry;
  logic         res_ovf;
  logic         res_err;
  logic         res_valid;
  logic         res_ack = 1'b0;
  logic         busy;

  int           tests = 0;
  int           fails = 0;
  int           pulses = 0;
  logic         prev_rd = 1'b0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] pending[$];

  alu_op_sequencer #(.DATA_WIDTH(W), .RD_WAIT(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_carry  (res_carry),
    .res_ovf    (res_ovf),
    .res_err    (res_err),
    .res_valid  (res_valid),
    .res_ack    (res_ack),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] b2w(input logic x);
    return {{(W-1){1'b0}}, x};
  endfunction

  function automatic logic [W-1:0] flags_now();
    return {28'b0, res_zero, res_carry, res_ovf, res_err};
  endfunction

  // Advance to the next falling edge; the FIFO model reacts to the strobe here.
  task automatic tick();
    @(negedge clock);
    if (fifo_rd) begin
      pulses++;
      check_eq("rd_prev_low", b2w(prev_rd), '0);
      if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    end
    prev_rd    = fifo_rd;
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Reference ALU: flags packed as {zero, carry, ovf, err}.
  function automatic void ref_alu(input logic [W-1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] data,
                                  output logic [3:0] flags);
    longint sa, sb, s, ua, ub;
    int     sh;
    logic   c, o, e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    c = 1'b0; o = 1'b0; e = 1'b0; data = '0;
    case (op % 16)
      0: begin
        data = a + b;
        c = (ua + ub) > 64'sd4294967295;
        s = sa + sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      1: begin
        data = a - b;
        c = (ua < ub);
        s = sa - sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2: data = a & b;
      3: data = a | b;
      4: data = a ^ b;
      5: data = a << sh;
      6: data = a >> sh;
      7: begin
        s = sa >>> sh;
        data = s[31:0];
      end
      8: data = (sa < sb) ? 32'd1 : 32'd0;
      9: data = (ua < ub) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    flags = {(data == 0), c, o, e};
  endfunction

  task automatic run_op(input logic [W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit stall, input bit backfill,
                        input bit prefilled, input bit check_lat, input bit noisy);
    logic [W-1:0] ed;
    logic [3:0]   ef;
    int           cyc;
    ref_alu(op, a, b, ed, ef);
    check_eq("idle_before", b2w(busy), '0);
    pulses = 0;
    if (!prefilled) begin
      push(op);
      push(a);
      if (!stall) push(b);
    end
    cyc = 0;
    if (stall) begin
      repeat (50) tick();
      cyc = 50;
      check_eq("stall_pulses", pulses, 2);
      check_eq("stall_rd", b2w(fifo_rd), '0);
      check_eq("stall_busy", b2w(busy), 32'd1);
      check_eq("stall_valid", b2w(res_valid), '0);
      push(b);
    end
    while (!res_valid && cyc < 300) begin
      tick();
      cyc++;
      res_ack = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (res_valid) res_ack = 1'b0;
    end
    res_ack = 1'b0;
    check_eq("valid", b2w(res_valid), 32'd1);
    if (check_lat) check_eq("latency", cyc, 16);
    check_eq("data", res_data, ed);
    check_eq("flags", flags_now(), {28'b0, ef});
    check_eq("pulses", pulses, 3);
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      if (backfill && i == 5) begin
        while (pending.size() > 0) push(pending.pop_front());
      end
      tick();
      check_eq("hold_valid", b2w(res_valid), 32'd1);
      check_eq("hold_data", res_data, ed);
    end
    if (hold > 0) check_eq("hold_pulses", pulses, 0);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check_eq("ack_clear", b2w(res_valid), '0);
    check_eq("post_data", res_data, ed);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] rop;
    repeat (3) tick();
    check_eq("rst_rd", b2w(fifo_rd), '0);
    check_eq("rst_busy", b2w(busy), '0);
    check_eq("rst_valid", b2w(res_valid), '0);
    check_eq("rst_data", res_data, '0);
    check_eq("rst_flags", flags_now(), '0);
    reset = 1'b0;
    tick();

    run_op(32'd0, 32'd5, 32'd7, 0, 0, 0, 0, 1, 0);
    run_op(32'd1, 32'd3, 32'd5, 2, 0, 0, 0, 1, 0);
    run_op(32'd0, 32'h7FFF_FFFF, 32'd1, 1, 0, 0, 0, 1, 0);
    run_op(32'd0, 32'hFFFF_FFFF, 32'd1, 1, 0, 0, 0, 1, 0);
    run_op(32'd7, 32'h8000_0000, 32'h24, 1, 0, 0, 0, 1, 0);
    run_op(32'd8, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, 0, 1, 0);
    run_op(32'hF, 32'd1, 32'd1, 1, 0, 0, 0, 1, 0);
    run_op(32'hABCD_0002, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0, 0, 0, 0);

    // Next operation's words arrive while the result is parked in DONE.
    pending.push_back(32'd3);
    pending.push_back(32'h0000_1234);
    pending.push_back(32'h0000_00F0);
    run_op(32'd4, 32'h5555_AAAA, 32'hFFFF_0000, 20, 0, 1, 0, 1, 0);
    run_op(32'd3, 32'h0000_1234, 32'h0000_00F0, 0, 0, 0, 1, 1, 0);

    // Reset while waiting on the second word's read latency.
    push(32'd1);
    push(32'd100);
    push(32'd1);
    repeat (7) tick();
    check_eq("mid_busy", b2w(busy), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("mrst_rd", b2w(fifo_rd), '0);
    check_eq("mrst_busy", b2w(busy), '0);
    check_eq("mrst_valid", b2w(res_valid), '0);
    check_eq("mrst_data", res_data, '0);
    check_eq("mrst_flags", flags_now(), '0);
    reset = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    tick();
    run_op(32'd0, 32'd5, 32'd7, 0, 0, 0, 0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      rop = $urandom;
      if ($urandom_range(0, 3) != 0) rop[3:0] = 4'($urandom_range(0, 9));
      run_op(rop, pick_operand(), pick_operand(), $urandom_range(0, 4), 0, 0, 0, 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
